// File: rtl/pipeline_debug_ctrl.sv
// Run/step/halt controller for the pipeline. It drives the pipeline enable, counts
// enabled cycles and streams out a captured snapshot of the pipeline state.
module pipeline_debug_ctrl #(
  parameter int NB_REG       = 32,
  parameter int N_SNAP_WORDS = 8
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_cmd_valid,
  input  logic [1:0]                     i_cmd,
  output logic                           o_cmd_ready,
  input  logic                           i_halt,
  input  logic [N_SNAP_WORDS*NB_REG-1:0] i_snap_bus,
  output logic                           o_valid,
  output logic [NB_REG-1:0]              o_n_clocks,
  output logic                           o_halted,
  output logic [NB_REG-1:0]              o_snap_data,
  output logic                           o_snap_valid,
  output logic                           o_snap_last,
  input  logic                           i_snap_ready
);

  localparam int NB_SNAP_IDX = $clog2(N_SNAP_WORDS + 1);
  localparam logic [NB_SNAP_IDX-1:0] LAST_IDX = NB_SNAP_IDX'(N_SNAP_WORDS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DUMP    = 3'd4;
  localparam logic [2:0] ST_HALTED  = 3'd5;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  logic [2:0]             state_q, state_d;
  logic [2:0]             ret_q, ret_d;
  logic                   halted_q, halted_d;
  logic                   valid_q;
  logic [NB_REG-1:0]      n_clocks_q;
  logic [NB_REG-1:0]      dump_q [N_SNAP_WORDS+1];
  logic [NB_SNAP_IDX-1:0] idx_q, idx_d, idx_inc;
  logic [NB_REG-1:0]      snap_data_q, snap_data_d;
  logic                   snap_valid_q, snap_valid_d;
  logic                   snap_last_q, snap_last_d;
  logic                   cmd_fire, snap_fire;

  assign o_cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign snap_fire    = snap_valid_q && i_snap_ready;
  assign idx_inc      = idx_q + 1'b1;

  assign o_valid      = valid_q;
  assign o_n_clocks   = n_clocks_q;
  assign o_halted     = halted_q;
  assign o_snap_data  = snap_data_q;
  assign o_snap_valid = snap_valid_q;
  assign o_snap_last  = snap_last_q;

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: begin
              state_d = ST_CAPTURE;
              ret_d   = ST_IDLE;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A retiring halt takes priority over a STOP in the same cycle.
        if (i_halt) begin
          state_d  = ST_CAPTURE;
          ret_d    = ST_HALTED;
          halted_d = 1'b1;
        end else if (cmd_fire && (i_cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        state_d = ST_CAPTURE;
        if (i_halt) begin
          ret_d    = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          ret_d = ST_IDLE;
        end
      end
      ST_CAPTURE: state_d = ST_DUMP;
      ST_DUMP: begin
        if (snap_fire && (idx_q == LAST_IDX)) state_d = ret_q;
      end
      ST_HALTED: begin
        if (cmd_fire && (i_cmd == CMD_DUMP)) begin
          state_d = ST_CAPTURE;
          ret_d   = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word 0 is loaded straight from the live counter, which is stable during capture.
  always_comb begin
    idx_d        = idx_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    snap_last_d  = snap_last_q;
    if (state_q == ST_CAPTURE) begin
      idx_d        = '0;
      snap_data_d  = n_clocks_q;
      snap_valid_d = 1'b1;
      snap_last_d  = 1'b0;
    end else if (snap_fire) begin
      if (idx_q == LAST_IDX) begin
        idx_d        = '0;
        snap_valid_d = 1'b0;
        snap_last_d  = 1'b0;
      end else begin
        idx_d       = idx_inc;
        snap_data_d = dump_q[idx_inc];
        snap_last_d = (idx_inc == LAST_IDX);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      halted_q     <= 1'b0;
      valid_q      <= 1'b0;
      n_clocks_q   <= '0;
      idx_q        <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= 1'b0;
      snap_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      halted_q     <= halted_d;
      valid_q      <= (state_d == ST_RUN) || (state_d == ST_STEP);
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      snap_last_q  <= snap_last_d;
      if (valid_q && (n_clocks_q != '1)) n_clocks_q <= n_clocks_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k <= N_SNAP_WORDS; k++) dump_q[k] <= '0;
    end else if (state_q == ST_CAPTURE) begin
      dump_q[0] <= n_clocks_q;
      for (int k = 0; k < N_SNAP_WORDS; k++) dump_q[k+1] <= i_snap_bus[k*NB_REG +: NB_REG];
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Bench for pipeline_debug_ctrl: directed scenarios plus randomized traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_pipeline_debug_ctrl;

  localparam int NB = 32;
  localparam int NW = 8;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_CAP = 3, M_DUMP = 4, M_HALT = 5;
  localparam logic [1:0] C_STOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_DUMP = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'b00;
  logic             halt = 1'b0;
  logic [NW*NB-1:0] bus = '0;
  logic             snap_ready = 1'b1;
  logic             o_cmd_ready, o_valid, o_halted, o_snap_valid, o_snap_last;
  logic [NB-1:0]    o_n_clocks, o_snap_data;

  // Narrow instance used only to reach counter saturation quickly.
  logic       cmd_valid4 = 1'b0;
  logic [1:0] cmd4 = 2'b00;
  logic [7:0] bus4 = 8'hBA;
  logic       rdy4, valid4, halted4, svalid4, slast4;
  logic [3:0] ncl4, sdata4;

  always #5 clk = ~clk;

  pipeline_debug_ctrl #(.NB_REG(NB), .N_SNAP_WORDS(NW)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt(halt), .i_snap_bus(bus), .o_valid(o_valid),
    .o_n_clocks(o_n_clocks), .o_halted(o_halted), .o_snap_data(o_snap_data),
    .o_snap_valid(o_snap_valid), .o_snap_last(o_snap_last), .i_snap_ready(snap_ready)
  );

  pipeline_debug_ctrl #(.NB_REG(4), .N_SNAP_WORDS(2)) dut4 (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid4), .i_cmd(cmd4),
    .o_cmd_ready(rdy4), .i_halt(1'b0), .i_snap_bus(bus4), .o_valid(valid4),
    .o_n_clocks(ncl4), .o_halted(halted4), .o_snap_data(sdata4),
    .o_snap_valid(svalid4), .o_snap_last(slast4), .i_snap_ready(1'b1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode, saturating count, sticky halt flag, queue of pending dump words.
  int          m_mode = M_IDLE;
  int          m_ret = M_IDLE;
  bit          m_halted = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_q[$];
  bit          m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_ret = M_IDLE; m_halted = 1'b0; m_cnt = '0; m_q.delete();
    end else begin
      m_acc = cmd_valid && (m_mode == M_IDLE || m_mode == M_RUN || m_mode == M_HALT);
      if ((m_mode == M_RUN || m_mode == M_STEP) && m_cnt < 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      case (m_mode)
        M_IDLE: if (m_acc) begin
          if (cmd == C_RUN) m_mode = M_RUN;
          else if (cmd == C_STEP) m_mode = M_STEP;
          else if (cmd == C_DUMP) begin m_mode = M_CAP; m_ret = M_IDLE; end
        end
        M_RUN, M_STEP: begin
          if (halt) begin m_halted = 1'b1; m_mode = M_CAP; m_ret = M_HALT; end
          else if (m_mode == M_STEP) begin m_mode = M_CAP; m_ret = M_IDLE; end
          else if (m_acc && cmd == C_STOP) m_mode = M_IDLE;
        end
        M_CAP: begin
          m_q.delete();
          m_q.push_back(m_cnt);
          for (int k = 0; k < NW; k++) m_q.push_back(bus[k*NB +: NB]);
          m_mode = M_DUMP;
        end
        M_DUMP: if (snap_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_mode = m_ret;
        end
        M_HALT: if (m_acc && cmd == C_DUMP) begin m_mode = M_CAP; m_ret = M_HALT; end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("o_valid", o_valid, (m_mode == M_RUN || m_mode == M_STEP));
    chk("o_cmd_ready", o_cmd_ready, (m_mode == M_IDLE || m_mode == M_RUN || m_mode == M_HALT));
    chk("o_halted", o_halted, m_halted);
    chk("o_n_clocks", o_n_clocks, m_cnt);
    chk("o_snap_valid", o_snap_valid, m_mode == M_DUMP);
    chk("o_snap_last", o_snap_last, (m_mode == M_DUMP && m_q.size() == 1));
    if (m_mode == M_DUMP && m_q.size() > 0) chk("o_snap_data", o_snap_data, m_q[0]);
  end

  // Dump consumer: 0 = always ready, 1 = alternating, 2 = random.
  int          rdy_mode = 0;
  bit          alt = 1'b0;
  logic [31:0] got[$];
  bit          got_last[$];
  int          n_vcyc = 0;

  always @(negedge clk) begin
    case (rdy_mode)
      0: snap_ready = 1'b1;
      1: begin alt = !alt; snap_ready = alt; end
      default: snap_ready = 1'($urandom_range(0, 1));
    endcase
    if (o_snap_valid && snap_ready) begin
      got.push_back(o_snap_data);
      got_last.push_back(o_snap_last);
    end
    if (o_valid) n_vcyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; halt = 1'b0; cmd_valid4 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input logic [1:0] c);
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd = c;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = o_cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", acc, 1'b1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 500 && got.size() < n; i++) tick();
    repeat (3) tick();
    chk("dump_word_count", got.size(), n);
  endtask

  task automatic set_bus_ramp();
    for (int k = 0; k < NW; k++) bus[k*NB +: NB] = 32'h100 + k;
  endtask

  int          base;
  logic [31:0] got4[$];
  bit          last4[$];

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_snap_data", o_snap_data, 32'h0);
    chk("reset_n_clocks", o_n_clocks, 32'h0);
    chk("reset_cmd_ready", o_cmd_ready, 1'b1);

    // Asynchronous reset in the middle of a run.
    send_cmd(C_RUN);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_valid, 1'b0);
    chk("async_rst_n_clocks", o_n_clocks, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", o_cmd_ready, 1'b1);
    $display("txn reset_mid_run done");

    // Run until a halt retires in the 5th enabled cycle.
    set_bus_ramp();
    rdy_mode = 0; got.delete(); got_last.delete();
    base = n_vcyc;
    send_cmd(C_RUN);
    for (int i = 0; i < 50 && (n_vcyc - base) < 5; i++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    wait_words(9);
    chk("halt_valid_cycles", n_vcyc - base, 5);
    chk("halt_sticky", o_halted, 1'b1);
    for (int i = 0; i < got.size(); i++) begin
      chk("halt_dump_word", got[i], (i == 0) ? 32'd5 : 32'h100 + 32'(i - 1));
      chk("halt_dump_last", got_last[i], i == 8);
    end
    base = n_vcyc;
    send_cmd(C_RUN);
    repeat (5) tick();
    chk("halted_ignores_run", n_vcyc - base, 0);
    $display("txn run_to_halt words=%0d", got.size());

    // Three single steps, each followed by its dump.
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      got.delete(); got_last.delete();
      base = n_vcyc;
      send_cmd(C_STEP);
      wait_words(9);
      chk("step_word0", (got.size() > 0) ? got[0] : 32'hDEAD, 32'(s));
      chk("step_pulses", n_vcyc - base, 1);
      $display("txn step %0d count=%0d", s, (got.size() > 0) ? got[0] : 0);
    end

    // Dump with alternating backpressure.
    do_reset();
    rdy_mode = 1; got.delete(); got_last.delete();
    send_cmd(C_DUMP);
    wait_words(9);
    for (int i = 0; i < got.size(); i++)
      chk("bp_dump_word", got[i], (i == 0) ? 32'd0 : 32'h100 + 32'(i - 1));
    $display("txn backpressure_dump handshakes=%0d", got.size());

    // STOP together with halt: the halt path must win.
    do_reset();
    rdy_mode = 0; got.delete(); got_last.delete();
    send_cmd(C_RUN);
    repeat (3) tick();
    halt = 1'b1; cmd_valid = 1'b1; cmd = C_STOP;
    tick();
    halt = 1'b0; cmd_valid = 1'b0;
    wait_words(9);
    chk("stop_halt_halted", o_halted, 1'b1);
    chk("stop_halt_word0", (got.size() > 0) ? got[0] : 32'hDEAD, 32'd4);
    $display("txn stop_with_halt words=%0d", got.size());

    // Randomized traffic; every cycle is checked against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rdy_mode = 2;
      for (int c = 0; c < 400; c++) begin
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd = 2'($urandom_range(0, 3));
        halt = ($urandom_range(0, 40) == 0);
        for (int k = 0; k < NW; k++) bus[k*NB +: NB] = $urandom;
        tick();
      end
      cmd_valid = 1'b0; halt = 1'b0;
      $display("txn random_round %0d halted=%0b n_clocks=%0d", r, o_halted, o_n_clocks);
    end

    // Saturation on the 4-bit counter.
    do_reset();
    cmd_valid4 = 1'b1; cmd4 = C_RUN;
    tick();
    cmd_valid4 = 1'b0;
    repeat (20) tick();
    cmd_valid4 = 1'b1; cmd4 = C_STOP;
    tick();
    cmd_valid4 = 1'b0;
    repeat (2) tick();
    chk("sat_n_clocks", ncl4, 4'd15);
    chk("sat_valid_off", valid4, 1'b0);
    repeat (3) tick();
    chk("sat_n_clocks_held", ncl4, 4'd15);
    cmd_valid4 = 1'b1; cmd4 = C_DUMP;
    tick();
    cmd_valid4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (svalid4) begin got4.push_back(32'(sdata4)); last4.push_back(slast4); end
      tick();
    end
    chk("sat_dump_count", got4.size(), 3);
    if (got4.size() == 3) begin
      chk("sat_word0", got4[0], 32'd15);
      chk("sat_word1", got4[1], 32'hA);
      chk("sat_word2", got4[2], 32'hB);
      chk("sat_last", {last4[0], last4[1], last4[2]}, 3'b001);
    end
    chk("sat_halted", halted4, 1'b0);
    chk("sat_ready", rdy4, 1'b1);
    $display("txn saturation n_clocks=%0d words=%0d", ncl4, got4.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Run/step/halt controller for the MIPS pipeline, providing the debug outputs the pipeline top does not yet have (valid-cycle count, state snapshot). It sits between the debug command source (host/UART side) and the pipeline top. It generates the pipeline's `i_valid` clock enable, counts executed cycles, and detects program halt. It captures a flat snapshot of pipeline state (PC, latches, selected registers) and streams it out word by word over a valid/ready handshake.

## Interface
Parameters:
- `NB_REG`, 32, width of every snapshot word and of the cycle counter
- `N_SNAP_WORDS`, 8, number of `NB_REG`-wide words on the snapshot bus
- `NB_SNAP_IDX`, clogb2(`N_SNAP_WORDS`+1), width of the dump word index (derived; do not override)

Ports:
- `i_clock`  in  1  single clock; all state changes on its rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_cmd_valid`  in  1  command strobe
- `i_cmd`  in  2  command code: 00 STOP, 01 RUN, 10 STEP, 11 DUMP
- `o_cmd_ready`  out  1  command accepted when `i_cmd_valid` and `o_cmd_ready` are both high at a rising edge
- `i_halt`  in  1  halt instruction retired in writeback; meaningful only in cycles where `o_valid`=1
- `i_snap_bus`  in  `N_SNAP_WORDS`*`NB_REG`  pipeline state; word k = bits [k*NB_REG +: NB_REG]
- `o_valid`  out  1  pipeline enable, drives pipeline `i_valid`; registered
- `o_n_clocks`  out  `NB_REG`  count of cycles with `o_valid`=1; saturating
- `o_halted`  out  1  sticky flag, high once halt is detected
- `o_snap_data`  out  `NB_REG`  dump word
- `o_snap_valid`  out  1  dump word valid
- `o_snap_last`  out  1  high together with the final dump word
- `i_snap_ready`  in  1  dump consumer ready

## Operation
- States: IDLE, RUN, STEP, CAPTURE, DUMP, HALTED.
- IDLE:
  - `o_cmd_ready`=1.
  - RUN goes to RUN. STEP goes to STEP. DUMP goes to CAPTURE with return state IDLE. STOP is a no-op.
- RUN:
  - `o_valid`=1 every cycle; `o_cmd_ready`=1.
  - `i_halt`=1 goes to CAPTURE with return state HALTED, and sets `o_halted`.
  - Otherwise an accepted STOP goes to IDLE.
  - RUN, STEP and DUMP commands are accepted and discarded.
  - `i_halt` and STOP in the same cycle: halt wins.
- STEP:
  - Lasts exactly one cycle with `o_valid`=1; `o_cmd_ready`=0.
  - `i_halt` is honoured as in RUN (return state HALTED); otherwise goes to CAPTURE with return state IDLE.
- CAPTURE:
  - Lasts one cycle; `o_valid`=0; `o_cmd_ready`=0.
  - At its closing edge, latches `i_snap_bus` and the current `o_n_clocks` into the snapshot registers.
  - The extra cycle lets pipeline latches settle after the last enabled edge.
  - Then goes to DUMP.
- DUMP:
  - `o_cmd_ready`=0.
  - Streams `N_SNAP_WORDS`+1 words: word 0 is the captured cycle count; words 1..N are `i_snap_bus` words 0..N-1.
  - The index advances only on `o_snap_valid` & `i_snap_ready`.
  - `o_snap_last`=1 while index = N.
  - After the final handshake, goes to the return state.
- HALTED:
  - `o_valid`=0; `o_cmd_ready`=1.
  - Only DUMP is acted on (goes to CAPTURE with return state HALTED); all other commands are discarded.
  - Left only by reset.
- Counter: increments by 1 on every edge where `o_valid`=1. It holds at all-ones and does not wrap.

## Timing
- Reset (`i_reset`=0, asynchronous): state IDLE.
  - `o_valid`, `o_halted`, `o_snap_valid`, `o_snap_last` = 0.
  - `o_n_clocks`, `o_snap_data`, snapshot registers and index = 0.
  - `o_cmd_ready`=1 (combinational from state).
- Reset mid-operation (RUN/DUMP) aborts immediately. A partial dump is dropped with no `o_snap_last`.
- A command accepted at edge t takes effect in the cycle after t: `o_valid`=1 from cycle t+1 for RUN and STEP.
- STEP sequence: cycle t+1 STEP (`o_valid`=1), t+2 CAPTURE, t+3 is the first DUMP cycle (`o_snap_valid`=1, word 0).
- Halt at cycle h (RUN, `o_valid`=1):
  - `o_valid`=0 and `o_halted`=1 from h+1.
  - Cycle h is counted.
  - CAPTURE at h+1, DUMP from h+2.
- Dump throughput is one word per cycle with `i_snap_ready` held at 1. `o_snap_valid`=0 the cycle after the last handshake.
- `o_snap_data`/`o_snap_last` hold stable while `o_snap_valid`=1 and `i_snap_ready`=0.
- `o_valid`, `o_n_clocks`, `o_halted`, `o_snap_*` are all registered outputs.

## Test plan
- Reset mid-RUN: RUN, run 10 cycles, drive `i_reset`=0 asynchronously. Required: `o_valid`=0 and `o_n_clocks`=0 with no clock edge; IDLE with `o_cmd_ready`=1 after release.
- Run to halt: RUN, `i_halt`=1 in the 5th `o_valid` cycle, `i_snap_ready`=1, `i_snap_bus` words = 0x100+k. Required:
  - exactly 5 `o_valid` cycles and `o_halted`=1;
  - dump of 9 words: 5, 0x100, …, 0x107, with `o_snap_last` on 0x107;
  - a later RUN is ignored (`o_valid` stays 0).
- Three STEPs, one after each dump completes. Required: one `o_valid` pulse per STEP; dump word 0 = 1, 2, 3 respectively.
- Dump backpressure: `i_snap_ready` alternating 0/1. Required: every word held stable during stall, no word skipped or repeated, 9 handshakes total.
- STOP and `i_halt` in the same RUN cycle. Required: HALTED path taken with a dump; `o_halted`=1.
- Saturation with `NB_REG`=4: RUN for 20 cycles then STOP, DUMP. Required: `o_n_clocks`=15 held; dump word 0 = 15.
